// File: rtl/rotary_pkg.sv
// Shared types and Gray-code table for the rotary encoder emulator.
package rotary_pkg;

  typedef enum logic {DirCw, DirCcw} rotary_dir_t;

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StRest} rotary_state_t;

  localparam logic [1:0] GRAY_CW [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Phase 1..3 are the codes of a detent; CCW walks the CW cycle backwards.
  function automatic logic [1:0] gray_code(input logic [1:0] phase, input rotary_dir_t dir);
    logic [1:0] idx;
    idx = (dir == DirCw) ? phase : 2'd0 - phase;
    return GRAY_CW[idx];
  endfunction

endpackage

// File: rtl/rotary_dwell_timer.sv
// Loadable down-counter; expire_o pulses for one cycle when a loaded count reaches zero.
module rotary_dwell_timer #(
  parameter int unsigned DWELL = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = LoadVal;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/rotary_emu.sv
// Quadrature generator: replays queued CW/CCW step requests as Gray-code detents.
module rotary_emu
  import rotary_pkg::*;
#(
  parameter int unsigned DWELL  = 1000,
  parameter int unsigned PEND_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_cw,
  input  logic       step_ccw,
  output logic [1:0] rotary_out,
  output logic       busy,
  output logic       step_done,
  output logic       overflow
);

  localparam int PendMax = 2 ** (PEND_W - 1) - 1;

  typedef logic signed [PEND_W-1:0] pend_t;
  // Two guard bits so the unclamped sum can never wrap.
  typedef logic signed [PEND_W+1:0] wide_t;

  localparam wide_t WOne = wide_t'(1);
  localparam wide_t WMax = wide_t'(PendMax);
  localparam wide_t WMin = wide_t'(-PendMax);

  rotary_state_t state_q, state_d;
  rotary_dir_t   dir_q, dir_d, start_dir;
  pend_t         pend_q, pend_d;
  logic [1:0]    out_q, out_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          load, expire, consume, pend_nz;
  wide_t         req, cons, sum;

  assign pend_nz   = (pend_q != '0);
  assign start_dir = pend_q[PEND_W-1] ? DirCcw : DirCw;

  rotary_dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    out_d   = out_q;
    done_d  = 1'b0;
    load    = 1'b0;
    consume = 1'b0;
    case (state_q)
      StIdle, StRest: begin
        if ((state_q == StIdle) || expire) begin
          if (pend_nz) begin
            consume = 1'b1;
            dir_d   = start_dir;
            out_d   = gray_code(2'd1, start_dir);
            load    = 1'b1;
            state_d = StPh1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StPh1: begin
        if (expire) begin
          out_d   = gray_code(2'd2, dir_q);
          load    = 1'b1;
          state_d = StPh2;
        end
      end
      StPh2: begin
        if (expire) begin
          out_d   = gray_code(2'd3, dir_q);
          load    = 1'b1;
          state_d = StPh3;
        end
      end
      StPh3: begin
        if (expire) begin
          out_d   = 2'b00;
          done_d  = 1'b1;
          load    = 1'b1;
          state_d = StRest;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Requests and consumption fold into a single saturating update.
  always_comb begin
    req = '0;
    if (step_cw && !step_ccw) begin
      req = WOne;
    end else if (step_ccw && !step_cw) begin
      req = -WOne;
    end
    cons = '0;
    if (consume) begin
      cons = pend_q[PEND_W-1] ? -WOne : WOne;
    end
    sum   = wide_t'(pend_q) + req - cons;
    ovf_d = ovf_q;
    if (sum > WMax) begin
      pend_d = pend_t'(WMax);
      ovf_d  = 1'b1;
    end else if (sum < WMin) begin
      pend_d = pend_t'(WMin);
      ovf_d  = 1'b1;
    end else begin
      pend_d = pend_t'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= DirCw;
      pend_q  <= '0;
      out_q   <= 2'b00;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rotary_out = out_q;
  assign step_done  = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle) || pend_nz;

endmodule
